// File: rtl/cpu_axi_bridge_pkg.sv
// Shared types and AXI constants for cpu_axi_bridge.
// Optional response checking is enabled by CPU_AXI_BRIDGE_RESP_CHECK_EN.
package cpu_axi_bridge_pkg;

  localparam int unsigned ID_W    = 4;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned LEN_W   = 4;
  localparam int unsigned SIZE_W  = 3;
  localparam int unsigned BURST_W = 2;
  localparam int unsigned STRB_W  = 4;
  localparam int unsigned RESP_W  = 2;

  localparam logic [BURST_W-1:0] BURST_INCR = 2'b01;
  localparam logic [SIZE_W-1:0]  SIZE_WORD  = 3'b010;
  localparam logic [RESP_W-1:0]  RESP_OKAY  = 2'b00;
  localparam logic [LEN_W-1:0]   LEN_SINGLE = 4'd0;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_RESP,
    DONE
  } state_t;

  // Request payload captured in IDLE and held until its handshake.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
  } req_t;

endpackage

// File: rtl/cpu_axi_bridge.sv
// CPU memory port to single-beat AXI4 master bridge; one instance per port.
// Define CPU_AXI_BRIDGE_RESP_CHECK_EN to latch non-OKAY R/B responses into resp_err.
module cpu_axi_bridge
  import cpu_axi_bridge_pkg::*;
#(
  parameter logic [ID_W-1:0] MASTER_ID = ID_W'(0)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_read,
  input  logic               req_write,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic [STRB_W-1:0]  req_wtype,
  input  logic [DATA_W-1:0]  req_wdata,
  output logic [DATA_W-1:0]  rdata,
  output logic               stall,
  output logic               resp_err,
  output logic [ID_W-1:0]    ARID,
  output logic [ADDR_W-1:0]  ARADDR,
  output logic [LEN_W-1:0]   ARLEN,
  output logic [SIZE_W-1:0]  ARSIZE,
  output logic [BURST_W-1:0] ARBURST,
  output logic               ARVALID,
  input  logic               ARREADY,
  input  logic [ID_W-1:0]    RID,
  input  logic [DATA_W-1:0]  RDATA,
  input  logic [RESP_W-1:0]  RRESP,
  input  logic               RLAST,
  input  logic               RVALID,
  output logic               RREADY,
  output logic [ID_W-1:0]    AWID,
  output logic [ADDR_W-1:0]  AWADDR,
  output logic [LEN_W-1:0]   AWLEN,
  output logic [SIZE_W-1:0]  AWSIZE,
  output logic [BURST_W-1:0] AWBURST,
  output logic               AWVALID,
  input  logic               AWREADY,
  output logic [DATA_W-1:0]  WDATA,
  output logic [STRB_W-1:0]  WSTRB,
  output logic               WLAST,
  output logic               WVALID,
  input  logic               WREADY,
  input  logic [ID_W-1:0]    BID,
  input  logic [RESP_W-1:0]  BRESP,
  input  logic               BVALID,
  output logic               BREADY
);

  state_t state, state_next;
  req_t   cap;
  logic   aw_done, w_done;
  logic   unused_in;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next state and handshake outputs; VALIDs decode registered state only.
  always_comb begin
    state_next = state;
    ARVALID    = 1'b0;
    RREADY     = 1'b0;
    AWVALID    = 1'b0;
    WVALID     = 1'b0;
    BREADY     = 1'b0;
    stall      = 1'b0;
    case (state)
      IDLE: begin
        stall = req_read || req_write;
        if (req_read)       state_next = RD_ADDR;
        else if (req_write) state_next = WR_REQ;
      end
      RD_ADDR: begin
        stall   = 1'b1;
        ARVALID = 1'b1;
        if (ARREADY) state_next = RD_DATA;
      end
      RD_DATA: begin
        stall  = 1'b1;
        RREADY = 1'b1;
        if (RVALID) state_next = DONE;
      end
      WR_REQ: begin
        stall   = 1'b1;
        AWVALID = !aw_done;
        WVALID  = !w_done;
        if ((aw_done || AWREADY) && (w_done || WREADY)) state_next = WR_RESP;
      end
      WR_RESP: begin
        stall  = 1'b1;
        BREADY = 1'b1;
        if (BVALID) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request capture, per-channel write completion flags and read data return.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap     <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      rdata   <= '0;
    end else begin
      if (state == IDLE) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
        if (req_read) begin
          cap.addr <= req_addr;
        end else if (req_write) begin
          cap.addr <= req_addr;
          cap.data <= req_wdata;
          cap.strb <= ~req_wtype;
        end
      end
      if (AWVALID && AWREADY) aw_done <= 1'b1;
      if (WVALID && WREADY)   w_done  <= 1'b1;
      if (state == RD_DATA && RVALID) rdata <= RDATA;
    end
  end

  assign ARID    = MASTER_ID;
  assign ARADDR  = cap.addr;
  assign ARLEN   = LEN_SINGLE;
  assign ARSIZE  = SIZE_WORD;
  assign ARBURST = BURST_INCR;
  assign AWID    = MASTER_ID;
  assign AWADDR  = cap.addr;
  assign AWLEN   = LEN_SINGLE;
  assign AWSIZE  = SIZE_WORD;
  assign AWBURST = BURST_INCR;
  assign WDATA   = cap.data;
  assign WSTRB   = cap.strb;
  assign WLAST   = 1'b1;

`ifdef CPU_AXI_BRIDGE_RESP_CHECK_EN
  // Sticky until reset; the read data is still returned on an errored read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_err <= 1'b0;
    end else if ((state == RD_DATA && RVALID && RRESP != RESP_OKAY) ||
                 (state == WR_RESP && BVALID && BRESP != RESP_OKAY)) begin
      resp_err <= 1'b1;
    end
  end
  assign unused_in = ^{RID, BID, RLAST};
`else
  assign resp_err  = 1'b0;
  assign unused_in = ^{RID, BID, RLAST, RRESP, BRESP};
`endif

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// Self-checking bench for cpu_axi_bridge: directed vector table, reset corner and
// randomized transactions against a cycle-count/scoreboard reference model.
module tb_cpu_axi_bridge;

  localparam logic [3:0] MID = 4'd5;
`ifdef CPU_AXI_BRIDGE_RESP_CHECK_EN
  localparam bit RESP_CHK = 1'b1;
`else
  localparam bit RESP_CHK = 1'b0;
`endif

  typedef struct {
    int          kind;      // 0 read, 1 write, 2 read+write together
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wtype;
    logic [31:0] rval;
    int          ar_w, r_w, aw_w, w_w, b_w;
    logic [1:0]  rresp, bresp;
    int          exp_stall;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_strb;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic req_read = 1'b0, req_write = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  req_wtype = 4'hF;
  logic [31:0] rdata;
  logic stall, resp_err;
  logic [3:0]  ARID, AWID, ARLEN, AWLEN;
  logic [31:0] ARADDR, AWADDR, WDATA;
  logic [2:0]  ARSIZE, AWSIZE;
  logic [1:0]  ARBURST, AWBURST;
  logic ARVALID, RREADY, AWVALID, WVALID, WLAST, BREADY;
  logic [3:0]  WSTRB;
  logic ARREADY = 1'b0, RVALID = 1'b0, AWREADY = 1'b0, WREADY = 1'b0, BVALID = 1'b0;
  logic [31:0] RDATA = '0;
  logic [1:0]  RRESP = '0, BRESP = '0;
  logic RLAST = 1'b1;
  logic [3:0]  RID = 4'd0, BID = 4'd0;

  int n_checks = 0, n_fail = 0;

  // Slave configuration and observations
  int ar_w, r_w, aw_w, w_w, b_w;
  logic [31:0] r_val;
  logic [1:0]  r_resp, b_resp;
  int ar_cnt, r_cnt, wr_cnt, b_cnt;
  int ar_hs, r_hs, aw_hs, w_hs, b_hs, b_wait;
  logic [31:0] ar_addr_s, aw_addr_s, w_data_s;
  logic [3:0]  w_strb_s;
  logic [12:0] ar_fix_s, aw_fix_s;
  logic        w_last_s;
  bit ar_pend, aw_pend, w_pend;
  logic [31:0] ar_pend_addr, aw_pend_addr;
  logic [35:0] w_pend_pay;

  logic [31:0] m_rdata = '0;
  logic        m_err = 1'b0;

  always #5 clk = ~clk;

  cpu_axi_bridge #(.MASTER_ID(MID)) dut (
    .clk(clk), .rst(rst),
    .req_read(req_read), .req_write(req_write), .req_addr(req_addr),
    .req_wtype(req_wtype), .req_wdata(req_wdata),
    .rdata(rdata), .stall(stall), .resp_err(resp_err),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Slave: responds on the falling edge, handshakes complete on the next rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      ARREADY = 1'b0; RVALID = 1'b0; AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0;
      ar_cnt = 0; r_cnt = 0; wr_cnt = 0; b_cnt = 0;
      ar_pend = 0; aw_pend = 0; w_pend = 0;
    end else begin
      if (ar_pend) check("ar_hold", {ARVALID, ARADDR}, {1'b1, ar_pend_addr});
      if (aw_pend) check("aw_hold", {AWVALID, AWADDR}, {1'b1, aw_pend_addr});
      if (w_pend)  check("w_hold", {WVALID, WDATA, WSTRB}, {1'b1, w_pend_pay});

      if (ARVALID) begin ARREADY = (ar_cnt >= ar_w); ar_cnt++; end
      else begin ARREADY = 1'b0; ar_cnt = 0; end
      if (RREADY) begin
        RVALID = (r_cnt >= r_w); RDATA = r_val; RRESP = r_resp; r_cnt++;
      end else begin RVALID = 1'b0; r_cnt = 0; end
      // Both write readies stay up while either channel is still pending.
      if (AWVALID || WVALID) begin
        AWREADY = (wr_cnt >= aw_w); WREADY = (wr_cnt >= w_w); wr_cnt++;
      end else begin AWREADY = 1'b0; WREADY = 1'b0; wr_cnt = 0; end
      if (BREADY) begin
        BVALID = (b_cnt >= b_w); BRESP = b_resp; b_cnt++;
        if (!BVALID) b_wait++;
      end else begin BVALID = 1'b0; b_cnt = 0; end

      if (ARVALID && ARREADY) begin
        ar_hs++; ar_addr_s = ARADDR; ar_fix_s = {ARID, ARLEN, ARSIZE, ARBURST};
      end
      if (RVALID && RREADY) r_hs++;
      if (AWVALID && AWREADY) begin
        aw_hs++; aw_addr_s = AWADDR; aw_fix_s = {AWID, AWLEN, AWSIZE, AWBURST};
      end
      if (WVALID && WREADY) begin
        w_hs++; w_data_s = WDATA; w_strb_s = WSTRB; w_last_s = WLAST;
      end
      if (BVALID && BREADY) b_hs++;

      ar_pend = ARVALID && !ARREADY; ar_pend_addr = ARADDR;
      aw_pend = AWVALID && !AWREADY; aw_pend_addr = AWADDR;
      w_pend  = WVALID && !WREADY;   w_pend_pay   = {WDATA, WSTRB};
    end
  end

  task automatic run_txn(input vec_t v);
    int  st_cnt;
    bit  done;
    bit  is_rd;
    @(negedge clk);
    ar_w = v.ar_w; r_w = v.r_w; aw_w = v.aw_w; w_w = v.w_w; b_w = v.b_w;
    r_val = v.rval; r_resp = v.rresp; b_resp = v.bresp;
    ar_hs = 0; r_hs = 0; aw_hs = 0; w_hs = 0; b_hs = 0; b_wait = 0;
    is_rd = (v.kind != 1);
    req_read = is_rd; req_write = (v.kind != 0);
    req_addr = v.addr; req_wdata = v.wdata; req_wtype = v.wtype;
    st_cnt = 0; done = 0;
    for (int c = 0; c < 300 && !done; c++) begin
      #1;
      if (stall) st_cnt++;
      else done = 1;
      if (!done) @(negedge clk);
    end
    req_read = 1'b0; req_write = 1'b0;
    req_addr = $urandom; req_wdata = $urandom; req_wtype = 4'($urandom);
    check("done_reached", 64'(done), 64'd1);
    m_err = m_err | (RESP_CHK && (is_rd ? (v.rresp != 2'b00) : (v.bresp != 2'b00)));
    check("stall_cycles", 64'(st_cnt), 64'(v.exp_stall));
    check("rdata", 64'(rdata), 64'(v.exp_rdata));
    check("resp_err", 64'(resp_err), 64'(m_err));
    check("done_idle_valids", {ARVALID, RREADY, AWVALID, WVALID, BREADY}, 64'd0);
    if (is_rd) begin
      check("rd_hs_counts", {8'(ar_hs), 8'(r_hs), 8'(aw_hs), 8'(w_hs), 8'(b_hs)},
            {8'd1, 8'd1, 8'd0, 8'd0, 8'd0});
      check("araddr", 64'(ar_addr_s), 64'(v.addr));
      check("ar_fixed", 64'(ar_fix_s), {51'd0, MID, 4'd0, 3'b010, 2'b01});
    end else begin
      check("wr_hs_counts", {8'(ar_hs), 8'(r_hs), 8'(aw_hs), 8'(w_hs), 8'(b_hs)},
            {8'd0, 8'd0, 8'd1, 8'd1, 8'd1});
      check("awaddr", 64'(aw_addr_s), 64'(v.addr));
      check("wdata_wlast", {w_last_s, w_data_s}, {1'b1, v.wdata});
      check("wstrb", 64'(w_strb_s), 64'(v.exp_strb));
      check("aw_fixed", 64'(aw_fix_s), {51'd0, MID, 4'd0, 3'b010, 2'b01});
      check("bready_wait", 64'(b_wait), 64'(v.b_w));
    end
    m_rdata = v.exp_rdata;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[9];
    vec_t v;
    // kind addr wdata wtype rval ar r aw w b rresp bresp stall rdata strb
    tbl[0] = '{0, 32'h10,  32'h0,        4'b0000, 32'hDEAD_BEEF, 0,0,0,0,0, 2'b00,2'b00, 3,  32'hDEAD_BEEF, 4'h0};
    tbl[1] = '{1, 32'h104, 32'h0000_00AB,4'b1100, 32'h0,         0,0,0,2,0, 2'b00,2'b00, 5,  32'hDEAD_BEEF, 4'b0011};
    tbl[2] = '{1, 32'h200, 32'h1234_5678,4'b0000, 32'h0,         0,0,2,0,5, 2'b00,2'b00, 10, 32'hDEAD_BEEF, 4'b1111};
    tbl[3] = '{2, 32'h300, 32'h5555_AAAA,4'b0000, 32'hCAFE_F00D, 0,0,0,0,0, 2'b00,2'b00, 3,  32'hCAFE_F00D, 4'h0};
    tbl[4] = '{0, 32'h44,  32'h0,        4'b1111, 32'h0BAD_F00D, 3,2,0,0,0, 2'b00,2'b00, 8,  32'h0BAD_F00D, 4'h0};
    tbl[5] = '{1, 32'h48,  32'hFFFF_FFFF,4'b1111, 32'h0,         0,0,1,1,0, 2'b00,2'b00, 4,  32'h0BAD_F00D, 4'b0000};
    tbl[6] = '{1, 32'h50,  32'hA5A5_5A5A,4'b0110, 32'h0,         0,0,0,0,1, 2'b00,2'b10, 4,  32'h0BAD_F00D, 4'b1001};
    tbl[7] = '{0, 32'h54,  32'h0,        4'b0000, 32'h1122_3344, 0,0,0,0,0, 2'b00,2'b00, 3,  32'h1122_3344, 4'h0};
    tbl[8] = '{0, 32'h58,  32'h0,        4'b0000, 32'h5566_7788, 0,1,0,0,0, 2'b11,2'b00, 4,  32'h5566_7788, 4'h0};

    ar_w = 0; r_w = 0; aw_w = 0; w_w = 0; b_w = 0;
    r_val = '0; r_resp = '0; b_resp = '0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_rdata", 64'(rdata), 64'd0);
    check("reset_stall_err", {stall, resp_err}, 64'd0);
    check("reset_valids", {ARVALID, RREADY, AWVALID, WVALID, BREADY}, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 9; i++) run_txn(tbl[i]);

    // Reset while waiting in RD_DATA: everything drops at once, next read is clean.
    @(negedge clk);
    ar_w = 0; r_w = 20; r_val = 32'h9999_9999; r_resp = 2'b00;
    req_read = 1'b1; req_addr = 32'h40;
    @(negedge clk);
    @(negedge clk);
    req_read = 1'b0;
    #1;
    check("pre_rst_rready", {ARVALID, RREADY}, 64'b01);
    #1 rst = 1'b0;
    #1;
    check("mid_rst_valids", {ARVALID, RREADY, AWVALID, WVALID, BREADY}, 64'd0);
    check("mid_rst_rdata", 64'(rdata), 64'd0);
    check("mid_rst_stall_err", {stall, resp_err}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    m_rdata = '0; m_err = 1'b0;
    v = '{0, 32'h60, 32'h0, 4'h0, 32'h0F0F_1234, 0,0,0,0,0, 2'b00,2'b00, 3, 32'h0F0F_1234, 4'h0};
    run_txn(v);

    // Randomized traffic; expectations from the cycle-count and scoreboard model.
    for (int i = 0; i < 40; i++) begin
      v.kind  = int'($urandom_range(0, 2));
      v.addr  = $urandom & 32'hFFFF_FFFC;
      v.wdata = $urandom;
      v.wtype = 4'($urandom);
      v.rval  = $urandom;
      v.ar_w  = int'($urandom_range(0, 4));
      v.r_w   = int'($urandom_range(0, 4));
      v.aw_w  = int'($urandom_range(0, 4));
      v.w_w   = int'($urandom_range(0, 4));
      v.b_w   = int'($urandom_range(0, 4));
      v.rresp = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00;
      v.bresp = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'b00;
      if (v.kind == 1) begin
        v.exp_stall = 3 + ((v.aw_w > v.w_w) ? v.aw_w : v.w_w) + v.b_w;
        v.exp_rdata = m_rdata;
      end else begin
        v.exp_stall = 3 + v.ar_w + v.r_w;
        v.exp_rdata = v.rval;
      end
      v.exp_strb = ~v.wtype;
      run_txn(v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_axi_bridge.md
# cpu_axi_bridge

Responder for one CPU memory port (instruction or data). It accepts the CPU's single-cycle-style read/write request and completes it as exactly one single-beat AXI4 transaction on a master interface. It drives one bit of the CPU `stalls` bus, and instantiates twice in the CPU wrapper: one instance for the instruction port, one for the data port. It returns read data with the same timing the pipeline expects from a synchronous memory.

## Interface
Parameters:
- `MASTER_ID`, default 4'd0: value driven on ARID/AWID.

Ports (AXI widths per `AXI_define.svh`: ID 4, ADDR 32, DATA 32, LEN 4, SIZE 3, BURST 2, STRB 4):
- `clk`  in  1  sole clock.
- `rst`  in  1  asynchronous, active-low reset.
- `req_read`  in  1  CPU read request (`instr_read` / `data_read`).
- `req_write`  in  1  CPU write request (`data_write`; tie 0 for instruction port).
- `req_addr`  in  32  byte address.
- `req_wtype`  in  4  active-low byte write enables, 4'b1111 = no bytes.
- `req_wdata`  in  32  write data, already lane-aligned.
- `rdata`  out  32  read data returned to the CPU (`instr` / `data_out`).
- `stall`  out  1  pipeline stall bit for this port.
- `resp_err`  out  1  sticky error flag (see Configuration).
- `ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID`  out  ID/ADDR/LEN/SIZE/BURST/1  read address channel.
- `ARREADY`  in  1  read address accept.
- `RID/RDATA/RRESP/RLAST/RVALID`  in  ID/DATA/2/1/1  read data channel.
- `RREADY`  out  1  read data accept.
- `AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID`  out  ID/ADDR/LEN/SIZE/BURST/1  write address channel.
- `AWREADY`  in  1  write address accept.
- `WDATA/WSTRB/WLAST/WVALID`  out  DATA/STRB/1/1  write data channel.
- `WREADY`  in  1  write data accept.
- `BID/BRESP/BVALID`  in  ID/2/1  write response channel.
- `BREADY`  out  1  write response accept.

## Operation
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- IDLE:
  - If `req_read`, capture the address and go to RD_ADDR.
  - Else if `req_write`, capture address, data and strobes, and go to WR_REQ.
  - If both are asserted, read wins; the write is dropped.
- RD_ADDR: ARVALID=1 until ARREADY, then go to RD_DATA.
- RD_DATA: RREADY=1. On RVALID, register RDATA into `rdata` and go to DONE.
- WR_REQ:
  - AWVALID and WVALID assert together.
  - Each drops independently after its own handshake; per-channel done flags track this, so AWREADY and WREADY may arrive in either order or together.
  - When both are done, go to WR_RESP.
- WR_RESP: BREADY=1. On BVALID, go to DONE.
- DONE: always returns to IDLE on the next cycle.
- Constant AXI fields:
  - ARLEN/AWLEN=0.
  - ARSIZE/AWSIZE=3'b010.
  - ARBURST/AWBURST=2'b01 (INCR).
  - WLAST=1.
- WSTRB = ~captured `req_wtype`. A write with all strobes low is still issued.
- Address, data and strobes are held stable from capture until their handshake completes. Later changes on `req_*` are ignored.
- `stall` (combinational):
  - 1 in IDLE when `req_read` or `req_write` is asserted.
  - 1 in RD_ADDR, RD_DATA, WR_REQ and WR_RESP.
  - 0 in DONE, and 0 in IDLE with no request.
- `rdata` holds its last value until the next R handshake.
- RID and BID are not checked.

## Timing
- Reset values: state IDLE; `rdata`=0; `resp_err`=0; all VALID/READY outputs 0; captured registers 0. Reset may occur mid-transaction: VALIDs drop asynchronously and there is no recovery of the lost transaction.
- Best-case read with ARREADY=1 and RVALID on the next cycle:
  - Request seen at cycle 0.
  - ARVALID at cycle 1; R handshake at cycle 2.
  - DONE at cycle 3, where `stall`=0 and `rdata` is valid.
  - `stall` is high for 3 cycles.
- Best-case write: AW/W handshake at cycle 1, B at cycle 2, DONE at cycle 3.
- Each slave wait cycle extends `stall` by exactly one cycle.
- Minimum spacing between accepted requests is 4 cycles (IDLE→…→DONE→IDLE).
- No output depends combinationally on any AXI input except through registered state.

## Configuration
- Macro `CPU_AXI_BRIDGE_RESP_CHECK_EN`.
- Defined:
  - RRESP≠2'b00 at the R handshake, or BRESP≠2'b00 at the B handshake, sets `resp_err`.
  - `resp_err` clears only on reset.
  - `rdata` is still updated on an errored read.
- Undefined: `resp_err` is tied to 0 and RRESP/BRESP are ignored.

## Structure
- Shared package `cpu_axi_bridge_pkg` holds:
  - the state enum;
  - constants `BURST_INCR`=2'b01, `SIZE_WORD`=3'b010, `RESP_OKAY`=2'b00, `LEN_SINGLE`=4'd0.
- The block is a single module with no sub-module. The FSM, capture registers and channel done flags are inline.

## Test plan
- Read 0x0000_0010, ARREADY=1, RVALID next cycle with RDATA=0xDEAD_BEEF → `stall` high for exactly 3 cycles, `rdata`=0xDEAD_BEEF in DONE, ARADDR=0x10, ARLEN=0.
- Write 0x0000_0104, `req_wtype`=4'b1100, data 0x0000_00AB, WREADY two cycles after AWREADY → WSTRB=4'b0011, AWVALID drops after the first handshake, WVALID held until WREADY, `stall` drops only in DONE.
- Write with WREADY asserted before AWREADY, BVALID delayed 5 cycles → no duplicate W beat, BREADY held 5 cycles, `stall` extended by 5 cycles.
- `req_read`=`req_write`=1 in IDLE → only the AR channel is issued, no AWVALID, one transaction total.
- With the macro defined, BRESP=2'b10 → `resp_err`=1 and it stays set across later OKAY transactions. Without the macro → `resp_err`=0.
- Assert `rst` low while in RD_DATA → ARVALID/RREADY are 0 immediately, `rdata`=0, `stall`=0 with no request; the next read completes normally.
